// File: rtl/vpu_mul_arbiter.sv
// Round-robin arbiter that time-shares one external combinational multiplier
// among NREQ requesters; one operation in flight, result returned per requester.
module vpu_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_c,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_c,
    output logic              busy
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_g;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_res;

    logic [W-1:0]    w_a [NREQ];
    logic [W-1:0]    w_b [NREQ];
    logic            w_found;
    logic [GW-1:0]   w_gnt_idx;
    logic [GW:0]     w_sum;
    logic [GW-1:0]   w_next_ptr;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_a[i] = req_a[i*W +: W];
            w_b[i] = req_b[i*W +: W];
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        // Scan from r_ptr upward, wrapping, and keep the first valid index.
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NREQ)) begin
                w_sum = w_sum - (GW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_sum[GW-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_sum[GW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == GW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_op_a  <= w_a[w_gnt_idx];
                        r_op_b  <= w_b[w_gnt_idx];
                        r_g     <= w_gnt_idx;
                        r_ptr   <= w_next_ptr;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res   <= mul_c;
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[r_g]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // req_ready is gated by rst_n so it reads zero while reset is held.
    assign req_ready = (rst_n && r_state == IDLE && w_found) ? (NREQ'(1) << w_gnt_idx) : '0;
    assign rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_g) : '0;
    assign rsp_c     = r_res;
    assign mul_a     = r_op_a;
    assign mul_b     = r_op_b;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_vpu_mul_arbiter.sv
// Self-checking bench for vpu_mul_arbiter: vector table plus scoreboard of
// expected responses, with hand-written round-robin, backpressure and reset sequences.
module tb_vpu_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int LIMIT = 30;

    typedef struct {
        int          req;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } vec_t;

    typedef struct {
        int          req;
        logic [W-1:0] c;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_c;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_c;
    logic              busy;

    logic signed [2*W-1:0] full_prod;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    vec_t         vt [5];
    logic [W-1:0] rr_a [NREQ];
    logic [W-1:0] rr_b [NREQ];
    logic [W-1:0] rr_c [NREQ];

    vpu_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .busy      (busy)
    );

    // Shared multiplier seen by the block: low W bits of the signed product.
    assign full_prod = $signed(mul_a) * $signed(mul_b);
    assign mul_c     = full_prod[W-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NREQ-1:0] oh(input int r);
        logic [NREQ-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every completed response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rsp_valid & rsp_ready) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_port", 64'(rsp_valid), 64'(oh(e.req)));
                check("rsp_c", 64'(rsp_c), 64'(e.c));
            end
        end
    end

    task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    task automatic set_rr_ops();
        for (int i = 0; i < NREQ; i++) set_ops(i, rr_a[i], rr_b[i]);
    endtask

    task automatic push(input int r, input logic [W-1:0] c);
        exp_t e;
        e.req = r;
        e.c   = c;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns at the negedge where a grant shows (or the bound expires).
    task automatic wait_grant(input string name, input logic [NREQ-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(req_ready), 64'(exp));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cyc;
        int prev_cyc;

        vt[0] = '{1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002};
        vt[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vt[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0002};
        vt[3] = '{0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vt[4] = '{0, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};

        rr_a[0] = 32'd3;      rr_b[0] = 32'd4;          rr_c[0] = 32'h0000_000C;
        rr_a[1] = -32'sd5;    rr_b[1] = 32'd6;          rr_c[1] = 32'hFFFF_FFE2;
        rr_a[2] = 32'd7;      rr_b[2] = -32'sd9;        rr_c[2] = 32'hFFFF_FFC1;
        rr_a[3] = 32'd100000; rr_b[3] = 32'd70000;      rr_c[3] = 32'hA13B_8600;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;

        // Reset held with random inputs: every output stays at zero.
        repeat (3) begin
            @(posedge clk);
            #1;
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
            @(negedge clk);
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_c", 64'(rsp_c), 64'(0));
            check("rst_mul_a", 64'(mul_a), 64'(0));
            check("rst_mul_b", 64'(mul_b), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
        end

        // Release: lowest-index valid requester wins from ptr=0.
        @(posedge clk);
        #1;
        set_rr_ops();
        req_valid = 4'b1100;
        rsp_ready = '1;
        rst_n     = 1'b1;
        wait_grant("first_grant", 4'b0100);
        push(2, rr_c[2]);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Table of single-requester operations with cycle-by-cycle checks.
        for (int v = 0; v < 5; v++) begin
            set_ops(vt[v].req, vt[v].a, vt[v].b);
            req_valid = oh(vt[v].req);
            @(negedge clk);
            check("tbl_ready", 64'(req_ready), 64'(oh(vt[v].req)));
            check("tbl_idle_busy", 64'(busy), 64'(0));
            push(vt[v].req, vt[v].c);
            @(posedge clk);
            #1;
            req_valid = '0;
            @(negedge clk);
            check("tbl_exec_busy", 64'(busy), 64'(1));
            check("tbl_exec_rsp_valid", 64'(rsp_valid), 64'(0));
            check("tbl_exec_ready", 64'(req_ready), 64'(0));
            check("tbl_mul_a", 64'(mul_a), 64'(vt[v].a));
            check("tbl_mul_b", 64'(mul_b), 64'(vt[v].b));
            @(negedge clk);
            check("tbl_resp_valid", 64'(rsp_valid), 64'(oh(vt[v].req)));
            check("tbl_resp_c", 64'(rsp_c), 64'(vt[v].c));
            @(negedge clk);
            check("tbl_done_busy", 64'(busy), 64'(0));
            @(posedge clk);
            #1;
        end
        check("tbl_sb_empty", 64'(sb.size()), 64'(0));

        // Round robin from a fresh reset: all four valid, grants 0,1,2,3,0 spaced 3 cycles.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rr_ops();
        rsp_ready = '1;
        req_valid = '1;
        prev_cyc  = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr_grant", oh(k % NREQ));
            acc_cyc = cyc;
            if (k > 0) check("rr_spacing", 64'(acc_cyc - prev_cyc), 64'(3));
            prev_cyc = acc_cyc;
            push(k % NREQ, rr_c[k % NREQ]);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain();

        // Backpressure: response held 5 cycles while others wait; next grant follows ptr.
        rsp_ready = '0;
        req_valid = '1;
        wait_grant("bp_grant", 4'b0010);
        push(1, rr_c[1]);
        @(posedge clk);
        #1;
        req_valid = 4'b1101;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
            check("bp_rsp_c", 64'(rsp_c), 64'(rr_c[1]));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        rsp_ready = '1;
        wait_grant("bp_next_grant", 4'b0100);
        push(2, rr_c[2]);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Reset during EXEC: operation dropped, ptr back to 0.
        req_valid = 4'b0100;
        wait_grant("rx_grant", 4'b0100);
        @(negedge clk);
        check("rx_exec_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rx_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rx_busy", 64'(busy), 64'(0));
        check("rx_mul_a", 64'(mul_a), 64'(0));
        check("rx_req_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b1101;
        wait_grant("rx_post_grant", 4'b0001);
        push(0, rr_c[0]);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Reset during RESP: response withdrawn immediately and never delivered.
        rsp_ready = '0;
        req_valid = 4'b1000;
        wait_grant("rr3_grant", 4'b1000);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("rs_resp_valid", 64'(rsp_valid), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        check("rs_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rs_rsp_c", 64'(rsp_c), 64'(0));
        check("rs_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = '1;
        repeat (4) @(negedge clk);
        check("rs_idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        req_valid = '1;
        wait_grant("rs_post_grant", 4'b0001);
        push(0, rr_c[0]);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_mul_arbiter.md
# vpu_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational signed 32-bit multiplier among NREQ requesters in the VPU. Each requester issues operand pairs over a valid/ready handshake. The block drives the shared multiplier from registered operands, captures the product, and returns it to the originating requester over a per-requester valid/ready response. One operation is outstanding at a time.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 32, operand/result width (signed)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request valid, bit i = requester i
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_a  in  NREQ*W  operand a, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand b, same packing
- rsp_valid  out  NREQ  response valid (one-hot or zero)
- rsp_ready  in  NREQ  response accept, bit i = requester i
- rsp_c  out  W  shared result bus, qualified by rsp_valid
- mul_a  out  W  operand a to shared multiplier
- mul_b  out  W  operand b to shared multiplier
- mul_c  in  W  product from shared multiplier (combinational, low W bits of signed a*b)
- busy  out  1  high when state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin search of req_valid starting at index ptr, wrapping NREQ-1 -> 0. First set bit is grant g.
  - req_ready[g]=1 combinationally in this cycle. Handshake completes when req_valid[g] && req_ready[g].
  - On the edge: capture req_a[g]/req_b[g] into op_a/op_b, store g, set ptr=(g+1) mod NREQ, go to EXEC.
  - No req_valid bit set: stay in IDLE, req_ready=0.
- EXEC:
  - mul_a=op_a, mul_b=op_b.
  - On the edge: capture mul_c into res, go to RESP.
- RESP:
  - rsp_valid[g]=1 and rsp_c=res.
  - On rsp_ready[g]: go to IDLE. rsp_ready on other bits is ignored.
- mul_a/mul_b are always driven from op_a/op_b. They change only at accept.
- Arithmetic: result is the low W bits of signed a*b, wrapping; no overflow flag. The block does not modify mul_c.
- req_ready=0 in EXEC and RESP. Requesters must hold req_valid and operands until accepted. Deasserting early is a protocol violation; the block does not detect it.

## Timing
- Reset values: state IDLE, ptr 0, op_a/op_b/res 0, g 0. Outputs req_ready 0, rsp_valid 0, rsp_c 0, mul_a/mul_b 0, busy 0.
- Latency:
  - Accept edge at cycle 0.
  - res is captured at edge 1.
  - rsp_valid is high from cycle 1 after edge 1, so it is visible 2 edges after the request was presented.
- Throughput: at most one operation per 3 cycles, because RESP always returns to IDLE before the next accept.
- The multiplier path is one full cycle, from op register to res register.
- rsp_valid[g] and rsp_c stay stable while rsp_ready[g]=0, for any number of cycles.
- Simultaneous requests: exactly one grant per accept. ptr rotates, so every continuously valid requester is served within NREQ operations.
- Requester g re-requesting immediately after its response loses priority to every other valid requester.
- rst_n asserted in any state:
  - All outputs go to reset values immediately, asynchronously.
  - The in-flight operation is dropped and no response is produced.
  - After release, the block starts in IDLE with ptr=0.

## Test plan
- Reset: hold rst_n low, drive random inputs -> all outputs 0, busy 0. Release -> first grant goes to the lowest-index valid requester.
- Single request on requester 1, a=0x00000001, b=0x00000002 -> req_ready[1] high for one cycle. rsp_valid[1] high 2 edges later with rsp_c=0x00000002, then busy falls after rsp_ready[1].
- Signed and wrap cases on requester 0:
  - 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFE
  - 0xFFFFFFFF*0xFFFFFFFE -> 0x00000002
  - 0x7FFFFFFF*0x00000002 -> 0xFFFFFFFE
  - 0x00000000*0x00000001 -> 0x00000000
- All four requesters held valid with distinct operands, rsp_ready tied high -> grant order 0,1,2,3,0. Each response appears on the matching rsp_valid bit with the correct product, and accepts are spaced 3 cycles apart.
- Backpressure: hold rsp_ready low for 5 cycles in RESP while other requesters are valid -> rsp_valid/rsp_c stable, req_ready stays 0. After release, the next grant follows ptr.
- Reset mid-operation: assert rst_n during EXEC and again during RESP -> rsp_valid drops immediately and no response is issued. After release, requester 0 is granted first.
